// File: rtl/div_unit_if.sv
// Handshake and operand bundle between the EX stage and the multi-cycle divider.
// The master modport is the EX side and the slave modport is the divider.
interface div_unit_if #(
  parameter int DATA_W = 32
);
  logic                  signed_div;
  logic [DATA_W-1:0]     opdata1;
  logic [DATA_W-1:0]     opdata2;
  logic                  start;
  logic                  annul;
  logic [2*DATA_W-1:0]   result;
  logic                  ready;

  modport master (
    output signed_div, opdata1, opdata2, start, annul,
    input  result, ready
  );

  modport slave (
    input  signed_div, opdata1, opdata2, start, annul,
    output result, ready
  );
endinterface

// File: rtl/div_unit.sv
// Restoring 32-bit DIV/DIVU unit for the HI/LO path. Result is {remainder, quotient}.
// One quotient bit per cycle on operand magnitudes, then a sign fix-up cycle.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  localparam logic [5:0] ITERS = 6'(DATA_W);

  state_t              state;
  logic [5:0]          cnt;
  logic [DATA_W-1:0]   dvd;   // dividend magnitude, shifts out as quotient shifts in
  logic [DATA_W-1:0]   dvs;
  logic [DATA_W-1:0]   rem;
  logic                qneg;
  logic                rneg;

  logic                s1;
  logic                s2;
  logic [DATA_W-1:0]   shifted;
  logic                fits;
  logic [DATA_W-1:0]   rem_next;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    s1       = bus.signed_div & bus.opdata1[DATA_W-1];
    s2       = bus.signed_div & bus.opdata2[DATA_W-1];
    // The partial remainder stays below the divisor, so the W-bit difference is exact.
    shifted  = {rem[DATA_W-2:0], dvd[DATA_W-1]};
    fits     = {rem, dvd[DATA_W-1]} >= {1'b0, dvs};
    rem_next = fits ? (shifted - dvs) : shifted;
    quo_fix  = qneg ? (~dvd + 1'b1) : dvd;
    rem_fix  = rneg ? (~rem + 1'b1) : rem;
  end

  // NOTE: sequential state uses non-blocking assignments only; the datapath registers
  // (dvd, dvs, rem, sign flags) carry no reset because FREE reloads them before use.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FREE;
      cnt        <= '0;
      bus.result <= '0;
      bus.ready  <= 1'b0;
    end else begin
      case (state)
        S_FREE: begin
          bus.ready  <= 1'b0;
          bus.result <= '0;
          if (bus.start && !bus.annul) begin
            if (bus.opdata2 == '0) begin
              state <= S_BYZERO;
            end else begin
              state <= S_ON;
              cnt   <= '0;
              dvd   <= s1 ? (~bus.opdata1 + 1'b1) : bus.opdata1;
              dvs   <= s2 ? (~bus.opdata2 + 1'b1) : bus.opdata2;
              qneg  <= s1 ^ s2;
              rneg  <= s1;
              rem   <= '0;
            end
          end
        end

        S_BYZERO: begin
          state      <= S_END;
          bus.result <= '0;
          bus.ready  <= 1'b1;
        end

        S_ON: begin
          if (bus.annul) begin
            state <= S_FREE;
          end else if (cnt < ITERS) begin
            rem <= rem_next;
            dvd <= {dvd[DATA_W-2:0], fits};
            cnt <= cnt + 6'd1;
          end else begin
            bus.result <= {rem_fix, quo_fix};
            bus.ready  <= 1'b1;
            state      <= S_END;
          end
        end

        S_END: begin
          // annul is ignored here: the result has already been presented to EX.
          if (!bus.start) begin
            state      <= S_FREE;
            bus.ready  <= 1'b0;
            bus.result <= '0;
          end
        end

        default: state <= S_FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus randomized DIV/DIVU
// operations compared against a plain-arithmetic reference.
module tb_div_unit;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  div_unit_if #(.DATA_W(W)) bus ();

  div_unit #(.DATA_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Reference: truncating division on 64-bit integers, wrapped back to 32 bits.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
    longint x, y, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start an operation, count edges to ready while scrambling operands, check
  // latency and result, check the hold, then drop start and check the clear.
  task automatic do_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input string tag);
    int n;
    int exp_lat;
    exp_lat        = (b == 32'd0) ? 2 : W + 2;
    bus.signed_div = sgn;
    bus.opdata1    = a;
    bus.opdata2    = b;
    bus.annul      = 1'b0;
    bus.start      = 1'b1;
    n = 0;
    while (1) begin
      step();
      n++;
      bus.opdata1    = $urandom;
      bus.opdata2    = $urandom;
      bus.signed_div = 1'($urandom_range(0, 1));
      if (bus.ready || n >= 60) break;
    end
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " result"}, bus.result, exp);
    step();
    check({tag, " hold"}, {bus.result[62:0], bus.ready}, {exp[62:0], 1'b1});
    bus.start = 1'b0;
    step();
    check({tag, " drop ready"}, 64'(bus.ready), 64'd0);
    check({tag, " drop result"}, bus.result, 64'd0);
  endtask

  initial begin
    logic        seen;
    logic        sgn;
    logic [31:0] a, b;

    bus.signed_div = 1'b0;
    bus.opdata1    = '0;
    bus.opdata2    = '0;
    bus.start      = 1'b0;
    bus.annul      = 1'b0;
    step();
    step();
    check("reset ready", 64'(bus.ready), 64'd0);
    check("reset result", bus.result, 64'd0);
    rst = 1'b0;
    step();

    do_op(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, "divu 100/7");
    do_op(1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, "div -7/2");
    do_op(1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, "div 7/-2");
    do_op(1'b0, 32'h12345678, 32'd0, 64'd0, "divu by zero");
    do_op(1'b1, 32'h80000001, 32'd0, 64'd0, "div by zero");
    do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, "div overflow");
    do_op(1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, "divu max/1");
    do_op(1'b0, 32'd5, 32'hFFFFFFFF, 64'h00000005_00000000, "divu small/max");

    // Annul at edge 10 of a long divide; ready must never appear.
    bus.signed_div = 1'b0;
    bus.opdata1    = 32'hFFFFFFFF;
    bus.opdata2    = 32'd3;
    bus.start      = 1'b1;
    for (int i = 0; i < 9; i++) step();
    bus.annul = 1'b1;
    bus.start = 1'b0;
    step();
    bus.annul = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      seen |= bus.ready;
    end
    check("annul no ready", 64'(seen), 64'd0);
    check("annul result", bus.result, 64'd0);
    do_op(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, "after annul 9/3");

    // start and annul together in FREE must not launch anything.
    bus.opdata1 = 32'd50;
    bus.opdata2 = 32'd5;
    bus.start   = 1'b1;
    bus.annul   = 1'b1;
    step();
    bus.start = 1'b0;
    bus.annul = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      seen |= bus.ready;
    end
    check("start+annul no op", 64'(seen), 64'd0);

    // Reset at edge 20 of a divide.
    bus.opdata1 = 32'hFFFFFFFF;
    bus.opdata2 = 32'd7;
    bus.start   = 1'b1;
    for (int i = 0; i < 19; i++) step();
    rst       = 1'b1;
    bus.start = 1'b0;
    step();
    check("mid reset ready", 64'(bus.ready), 64'd0);
    check("mid reset result", bus.result, 64'd0);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      seen |= bus.ready;
    end
    check("after reset idle", 64'(seen), 64'd0);
    do_op(1'b0, 32'd10, 32'd4, 64'h00000002_00000002, "after reset 10/4");

    for (int k = 0; k < 24; k++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 16));
        2:       b = 32'hFFFFFFFF - 32'($urandom_range(0, 15));
        default: b = $urandom;
      endcase
      if (k % 5 == 0) a = 32'h80000000;
      do_op(sgn, a, b, ref_div(sgn, a, b), $sformatf("rand %0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
